// File: rtl/qsys_serial_pkg.sv
// Shared constants, state encoding and helpers for the Qsys serial link endpoint.
package qsys_serial_pkg;

    localparam int unsigned FRAME_BITS   = 65;
    localparam int unsigned RW_BIT       = 64;
    localparam int unsigned RESP_BITS    = 32;
    localparam logic [31:0] TIMEOUT_RESP = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        SHIFT_IN      = 3'd1,
        DECODE        = 3'd2,
        BUS_REQ       = 3'd3,
        BUS_WAIT_DATA = 3'd4,
        RESP_LOAD     = 3'd5,
        RESP_SHIFT    = 3'd6
    } qsys_state_e;

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == 7'd127) ? v : (v + 7'd1);
    endfunction

endpackage

// File: rtl/qsys_serial_shifter.sv
// Generic shift register: parallel load, serial in at the LSB, serial out from the MSB.
module qsys_serial_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    logic [WIDTH-1:0] q_r;

    // Parallel load takes priority over shifting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= load_data;
        end else if (shift_en) begin
            q_r <= {q_r[WIDTH-2:0], sin};
        end else begin
            q_r <= q_r;
        end
    end

    assign q    = q_r;
    assign sout = q_r[WIDTH-1];

endmodule

// File: rtl/qsys_serial_slave.sv
// Far-end Qsys serial endpoint: 65-bit command in, one Avalon-MM access, 32-bit response out.
// Optional local-bus timeout is enabled with `define QSYS_SERIAL_SLAVE_TIMEOUT_EN.
module qsys_serial_slave
    import qsys_serial_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned RESP_PAD       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              csi_MCLK_clk,
    input  logic              rsi_MRST_reset,
    input  logic              coe_sdi,
    input  logic              coe_sle,
    output logic              coe_sdo,
    output logic              coe_srdy,
    output logic [ADDR_W-1:0] avm_local_address,
    output logic [31:0]       avm_local_writedata,
    output logic [3:0]        avm_local_byteenable,
    output logic              avm_local_write,
    output logic              avm_local_read,
    input  logic [31:0]       avm_local_readdata,
    input  logic              avm_local_waitrequest,
    input  logic              avm_local_readdatavalid,
    output logic              frame_err
);

    localparam int unsigned RESP_W    = RESP_PAD + RESP_BITS;
    localparam logic [6:0]  RESP_LAST = 7'(RESP_W - 1);
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
`ifdef QSYS_SERIAL_SLAVE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    qsys_state_e        state_r, state_s;
    logic [6:0]         bit_cnt_r, bit_cnt_s;
    logic               sle_d_r;
    logic               ovr_hold_r, ovr_hold_s;
    logic               rw_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [31:0]        wdata_r;
    logic               write_r, write_s;
    logic               read_r, read_s;
    logic [31:0]        resp_r, resp_s;
    logic               sdo_r, srdy_r, frame_err_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               tmo_hit_s, ovr_s;
    logic               cmd_shift_s, resp_load_s, resp_shift_s, latch_s, err_s;
    logic [FRAME_BITS-1:0] cmd_q_s;
    logic [RESP_W-1:0]  resp_q_s;
    logic               cmd_sout_s, resp_sout_s;

    qsys_serial_shifter #(.WIDTH(FRAME_BITS)) u_cmd_shift (
        .clk       (csi_MCLK_clk),
        .rst       (rsi_MRST_reset),
        .load      (1'b0),
        .load_data ({FRAME_BITS{1'b0}}),
        .shift_en  (cmd_shift_s),
        .sin       (coe_sdi),
        .q         (cmd_q_s),
        .sout      (cmd_sout_s)
    );

    qsys_serial_shifter #(.WIDTH(RESP_W)) u_resp_shift (
        .clk       (csi_MCLK_clk),
        .rst       (rsi_MRST_reset),
        .load      (resp_load_s),
        .load_data (RESP_W'(resp_r)),
        .shift_en  (resp_shift_s),
        .sin       (1'b0),
        .q         (resp_q_s),
        .sout      (resp_sout_s)
    );

    // A new sle edge outside the receive states is an overrun; its bits are ignored
    assign ovr_s     = coe_sle & ~sle_d_r & (state_r != IDLE) & (state_r != SHIFT_IN);
    assign tmo_hit_s = TMO_EN && (tmo_cnt_r >= TMO_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter advances only while a local access is outstanding
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            tmo_cnt_r <= '0;
        end else if (TMO_EN && ((state_r == BUS_REQ) || (state_r == BUS_WAIT_DATA))) begin
            tmo_cnt_r <= tmo_hit_s ? tmo_cnt_r : (tmo_cnt_r + TMO_W'(1));
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // State register
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, request and response control
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        ovr_hold_s   = (ovr_hold_r & coe_sle) | ovr_s;
        write_s      = write_r;
        read_s       = read_r;
        resp_s       = resp_r;
        cmd_shift_s  = 1'b0;
        resp_load_s  = 1'b0;
        resp_shift_s = 1'b0;
        latch_s      = 1'b0;
        err_s        = ovr_s;
        case (state_r)
            IDLE: begin
                if (coe_sle && !ovr_hold_r) begin
                    cmd_shift_s = 1'b1;
                    bit_cnt_s   = 7'd1;
                    state_s     = SHIFT_IN;
                end else begin
                    bit_cnt_s   = 7'd0;
                end
            end
            SHIFT_IN: begin
                if (coe_sle) begin
                    cmd_shift_s = 1'b1;
                    bit_cnt_s   = sat_inc7(bit_cnt_r);
                end else if (bit_cnt_r >= 7'(FRAME_BITS)) begin
                    state_s     = DECODE;
                end else begin
                    err_s       = 1'b1;
                    bit_cnt_s   = 7'd0;
                    state_s     = IDLE;
                end
            end
            DECODE: begin
                latch_s = 1'b1;
                write_s = cmd_q_s[RW_BIT];
                read_s  = ~cmd_q_s[RW_BIT];
                state_s = BUS_REQ;
            end
            BUS_REQ: begin
                if (!avm_local_waitrequest) begin
                    write_s = 1'b0;
                    read_s  = 1'b0;
                    if (rw_r) begin
                        resp_s  = 32'h0000_0000;
                        state_s = RESP_LOAD;
                    end else if (avm_local_readdatavalid) begin
                        resp_s  = avm_local_readdata;
                        state_s = RESP_LOAD;
                    end else begin
                        state_s = BUS_WAIT_DATA;
                    end
                end else if (tmo_hit_s) begin
                    write_s = 1'b0;
                    read_s  = 1'b0;
                    resp_s  = TIMEOUT_RESP;
                    err_s   = 1'b1;
                    state_s = RESP_LOAD;
                end else begin
                    state_s = BUS_REQ;
                end
            end
            BUS_WAIT_DATA: begin
                if (avm_local_readdatavalid) begin
                    resp_s  = avm_local_readdata;
                    state_s = RESP_LOAD;
                end else if (tmo_hit_s) begin
                    resp_s  = TIMEOUT_RESP;
                    err_s   = 1'b1;
                    state_s = RESP_LOAD;
                end else begin
                    state_s = BUS_WAIT_DATA;
                end
            end
            RESP_LOAD: begin
                resp_load_s = 1'b1;
                bit_cnt_s   = 7'd0;
                state_s     = RESP_SHIFT;
            end
            RESP_SHIFT: begin
                resp_shift_s = 1'b1;
                if (bit_cnt_r == RESP_LAST) begin
                    bit_cnt_s = 7'd0;
                    state_s   = IDLE;
                end else begin
                    bit_cnt_s = bit_cnt_r + 7'd1;
                end
            end
            default: begin
                write_s = 1'b0;
                read_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; srdy/sdo trail the shifter by one cycle
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            bit_cnt_r   <= 7'd0;
            sle_d_r     <= 1'b0;
            ovr_hold_r  <= 1'b0;
            rw_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            write_r     <= 1'b0;
            read_r      <= 1'b0;
            resp_r      <= 32'h0000_0000;
            sdo_r       <= 1'b0;
            srdy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            bit_cnt_r   <= bit_cnt_s;
            sle_d_r     <= coe_sle;
            ovr_hold_r  <= ovr_hold_s;
            write_r     <= write_s;
            read_r      <= read_s;
            resp_r      <= resp_s;
            sdo_r       <= resp_shift_s & resp_sout_s;
            srdy_r      <= resp_shift_s;
            frame_err_r <= err_s;
            if (latch_s) begin
                rw_r    <= cmd_q_s[RW_BIT];
                addr_r  <= cmd_q_s[32 +: ADDR_W];
                wdata_r <= cmd_q_s[31:0];
            end else begin
                rw_r    <= rw_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
        end
    end

    assign coe_sdo              = sdo_r;
    assign coe_srdy             = srdy_r;
    assign avm_local_address    = addr_r;
    assign avm_local_writedata  = wdata_r;
    assign avm_local_byteenable = 4'hF;
    assign avm_local_write      = write_r;
    assign avm_local_read       = read_r;
    assign frame_err            = frame_err_r;

endmodule

// File: tb/tb_qsys_serial_slave.sv
// Randomised self-checking bench for qsys_serial_slave against a memory-level reference model.
module tb_qsys_serial_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdi, sle;
    logic        sdo, srdy;
    logic [7:0]  addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        wr_o, rd_o;
    logic [31:0] readdata;
    logic        waitreq, rdv;
    logic        ferr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] bus_mem [256];
    int          cfg_stall = 0;
    int          cfg_lat   = 0;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;

    int          mon_wr, mon_rd, mon_bad, mon_srdy, mon_err;
    logic [32:0] mon_resp;

    always #5 clk = ~clk;

    qsys_serial_slave dut (
        .csi_MCLK_clk            (clk),
        .rsi_MRST_reset          (rst),
        .coe_sdi                 (sdi),
        .coe_sle                 (sle),
        .coe_sdo                 (sdo),
        .coe_srdy                (srdy),
        .avm_local_address       (addr_o),
        .avm_local_writedata     (wdata_o),
        .avm_local_byteenable    (be_o),
        .avm_local_write         (wr_o),
        .avm_local_read          (rd_o),
        .avm_local_readdata      (readdata),
        .avm_local_waitrequest   (waitreq),
        .avm_local_readdatavalid (rdv),
        .frame_err               (ferr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: strobe counts, request stability, response capture, error pulses
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (wr_o) begin
                mon_wr++;
                if (addr_o !== exp_addr || wdata_o !== exp_wdata) mon_bad++;
            end
            if (rd_o) begin
                mon_rd++;
                if (addr_o !== exp_addr) mon_bad++;
            end
            if (srdy) begin
                mon_srdy++;
                mon_resp = {mon_resp[31:0], sdo};
            end
            if (ferr) mon_err++;
        end
    end

    // Local-bus slave: stalls cfg_stall cycles, returns read data cfg_lat cycles after accept
    initial begin : bus_slave
        int         left, rd_left;
        bit         busy, pend;
        logic [7:0] a;
        waitreq = 1'b0; rdv = 1'b0; readdata = 32'h0;
        busy = 1'b0; pend = 1'b0; left = 0; rd_left = 0; a = 8'h00;
        forever begin
            @(negedge clk);
            rdv      = 1'b0;
            readdata = $urandom;
            if (pend) begin
                rd_left--;
                if (rd_left == 0) begin
                    rdv = 1'b1; readdata = bus_mem[a]; pend = 1'b0;
                end
            end
            if (wr_o || rd_o) begin
                if (!busy) begin busy = 1'b1; left = cfg_stall; end
                if (left > 0) begin
                    waitreq = 1'b1; left--;
                end else begin
                    waitreq = 1'b0; busy = 1'b0; a = addr_o;
                    if (wr_o) bus_mem[a] = wdata_o;
                    else if (cfg_lat == 0) begin rdv = 1'b1; readdata = bus_mem[a]; end
                    else begin pend = 1'b1; rd_left = cfg_lat; end
                end
            end else begin
                waitreq = 1'b0;
            end
        end
    end

    task automatic clr_mon();
        mon_wr = 0; mon_rd = 0; mon_bad = 0; mon_srdy = 0; mon_err = 0; mon_resp = 33'h0;
    endtask

    task automatic send_bits(input logic [127:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            sle = 1'b1; sdi = bits[i];
        end
        @(negedge clk);
        sle = 1'b0; sdi = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 800 && !done; i++) begin
            @(negedge clk);
            if (srdy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check_eq($sformatf("%s/resp_done", tag), 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic run_txn(input string tag, input logic rw, input logic [31:0] addr,
                           input logic [31:0] data, input int stall, input int lat,
                           input int pre_bits, input bit overrun);
        logic [127:0] bits;
        logic [31:0]  exp_resp;
        int           n_req;
        cfg_stall = stall; cfg_lat = lat;
        exp_addr  = addr[7:0];
        exp_wdata = data;
        n_req     = stall + 1;
        if (rw) begin
            ref_mem[addr[7:0]] = data;
            exp_resp = 32'h0;
        end else begin
            exp_resp = ref_mem[addr[7:0]];
        end
        bits = {63'($urandom), rw, addr, data};
        clr_mon();
        send_bits(bits, 65 + pre_bits);
        if (overrun) begin
            repeat (3) @(negedge clk);
            sle = 1'b1; sdi = 1'($urandom);
            repeat (3) @(negedge clk);
            sle = 1'b0; sdi = 1'b0;
        end
        wait_resp(tag);
        check_eq($sformatf("%s/wr_cycles", tag), 64'(mon_wr), rw ? 64'(n_req) : 64'd0);
        check_eq($sformatf("%s/rd_cycles", tag), 64'(mon_rd), rw ? 64'd0 : 64'(n_req));
        check_eq($sformatf("%s/req_stable", tag), 64'(mon_bad), 64'd0);
        check_eq($sformatf("%s/srdy_cycles", tag), 64'(mon_srdy), 64'd33);
        check_eq($sformatf("%s/resp", tag), 64'(mon_resp), 64'({1'b0, exp_resp}));
        check_eq($sformatf("%s/frame_err", tag), 64'(mon_err), overrun ? 64'd1 : 64'd0);
    endtask

    task automatic run_short(input string tag, input int n);
        clr_mon();
        send_bits({$urandom, $urandom, $urandom, $urandom}, n);
        repeat (12) @(negedge clk);
        check_eq($sformatf("%s/frame_err", tag), 64'(mon_err), 64'd1);
        check_eq($sformatf("%s/strobes", tag), 64'(mon_wr + mon_rd), 64'd0);
        check_eq($sformatf("%s/srdy", tag), 64'(mon_srdy), 64'd0);
    endtask

    initial begin : main
        bit seen;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end
        ref_mem[8'hA0] = 32'hCAFEF00D;
        bus_mem[8'hA0] = 32'hCAFEF00D;
        rst = 1'b1; sle = 1'b0; sdi = 1'b0;
        exp_addr = 8'h00; exp_wdata = 32'h0;
        clr_mon();
        repeat (3) @(negedge clk);
        check_eq("rst/srdy", 64'(srdy), 64'd0);
        check_eq("rst/sdo", 64'(sdo), 64'd0);
        check_eq("rst/write", 64'(wr_o), 64'd0);
        check_eq("rst/read", 64'(rd_o), 64'd0);
        check_eq("rst/addr", 64'(addr_o), 64'd0);
        check_eq("rst/wdata", 64'(wdata_o), 64'd0);
        check_eq("rst/frame_err", 64'(ferr), 64'd0);
        check_eq("rst/byteenable", 64'(be_o), 64'hF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn("wr05", 1'b1, 32'h0000_0005, 32'h1234_5678, 0, 0, 0, 1'b0);
        run_txn("rdA0", 1'b0, 32'h0000_00A0, 32'h0, 0, 3, 0, 1'b0);
        run_txn("wr_stall10", 1'b1, 32'hFFFF_FF33, 32'hA5A5_0F0F, 10, 0, 0, 1'b0);
        run_txn("rd_back33", 1'b0, 32'h0000_0033, 32'h0, 2, 0, 0, 1'b0);
        run_short("short40", 40);
        run_txn("after_short", 1'b0, 32'h0000_0005, 32'h0, 1, 1, 0, 1'b0);
        run_short("short64", 64);
        run_txn("long80", 1'b1, 32'h1234_5611, 32'h0BAD_CAFE, 0, 0, 15, 1'b0);
        run_txn("overrun", 1'b0, 32'h0000_0011, 32'h0, 10, 4, 0, 1'b1);

        // Reset in the middle of the response window
        clr_mon();
        cfg_stall = 0; cfg_lat = 1;
        exp_addr = 8'hA0; exp_wdata = 32'h0;
        send_bits({63'd0, 1'b0, 32'h0000_00A0, 32'h0}, 65);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (srdy) seen = 1'b1;
        end
        check_eq("midrst/srdy_seen", 64'(seen), 64'd1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst/srdy", 64'(srdy), 64'd0);
        check_eq("midrst/sdo", 64'(sdo), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_txn("post_rst", 1'b0, 32'h0000_00A0, 32'h0, 0, 2, 0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            logic        rw;
            logic [31:0] addr;
            rw   = 1'($urandom);
            addr = {24'($urandom), 5'd0, 3'($urandom_range(0, 7))};
            run_txn($sformatf("rand%0d", t), rw, addr, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
